// File: rtl/synth_step_sequencer.sv
// Autonomous step sequencer: plays {gate, divisor} steps from a small pattern
// memory, producing the voice pitch divisor and envelope trigger per step.
module synth_step_sequencer #(
  parameter int STEPS      = 16,
  parameter int GATE_SHIFT = 8,
  localparam int AW        = $clog2(STEPS)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          step_we,
  input  logic [AW-1:0] step_addr,
  input  logic [31:0]   step_divisor,
  input  logic [7:0]    step_gate,
  input  logic          run,
  input  logic          oneshot,
  input  logic [26:0]   step_period,
  input  logic [AW-1:0] last_step,
  output logic [31:0]   divisor,
  output logic          trigger,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          step_pulse,
  output logic          done
);

  localparam int GW = 8 + GATE_SHIFT;

  typedef enum logic [1:0] {IDLE, PLAY, STOP} state_t;

  logic [39:0]   mem [STEPS];

  state_t        state_q, state_d;
  logic          run_prev_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [26:0]   cnt_q, cnt_d;
  logic [26:0]   per_q, per_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [AW-1:0] last_q, last_d;
  logic [31:0]   div_q, div_d;
  logic          trig_q, trig_d;
  logic          busy_q, busy_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;

  logic          load_en;
  logic [AW-1:0] load_idx;
  logic [39:0]   rd;
  logic [27:0]   cnt_nx;

  // Pattern memory write port; reads below see the pre-write contents.
  always_ff @(posedge wb_clk_i) begin
    if (step_we) mem[step_addr] <= {step_gate, step_divisor};
  end

  // Next-state: step timing, advance/wrap/stop decisions and step loading.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    gate_d   = gate_q;
    last_d   = last_q;
    div_d    = div_q;
    trig_d   = 1'b0;
    busy_d   = busy_q;
    pulse_d  = 1'b0;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_idx = idx_q;
    cnt_nx   = {1'b0, cnt_q} + 28'd1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (run && !run_prev_q) begin
          load_en  = 1'b1;
          load_idx = '0;
        end
      end
      PLAY: begin
        if (!run) begin
          // Abort: drop the gate immediately, keep the last pitch.
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == per_q - 27'd1) begin
          if (idx_q != last_q) begin
            load_en  = 1'b1;
            load_idx = idx_q + AW'(1);
          end else if (!oneshot) begin
            load_en  = 1'b1;
            load_idx = '0;
          end else begin
            state_d = STOP;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
          end
        end else begin
          cnt_d  = cnt_nx[26:0];
          // Gate is held for min(G, P-1) cycles so the step's last cycle is low.
          trig_d = (cnt_nx < 28'(gate_q)) && (cnt_nx < ({1'b0, per_q} - 28'd1));
        end
      end
      STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd = mem[load_idx];
    if (load_en) begin
      state_d = PLAY;
      idx_d   = load_idx;
      cnt_d   = '0;
      div_d   = rd[31:0];
      gate_d  = GW'(rd[39:32]) << GATE_SHIFT;
      per_d   = (step_period < 27'd2) ? 27'd2 : step_period;
      last_d  = last_step;
      pulse_d = 1'b1;
      trig_d  = (rd[39:32] != 8'd0);
      busy_d  = 1'b1;
    end
  end

  // State and registered outputs; reset clears control and visible outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      run_prev_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= run;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
    per_q  <= per_d;
    gate_q <= gate_d;
    last_q <= last_d;
  end

  assign divisor    = div_q;
  assign trigger    = trig_q;
  assign step_idx   = idx_q;
  assign busy       = busy_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;

endmodule

// File: doc/synth_step_sequencer.md
# synth_step_sequencer

Autonomous step sequencer that drives the voice's `divisor` (pitch) and `trigger` (envelope gate) inputs from a small on-chip pattern memory, so notes play without per-note CPU writes. It sits between the Wishbone register block and the voice datapath. When `run` is low, it muxes control to the register-block values outside this block. Software loads steps through a simple write port, sets tempo and loop length, and raises `run`.

## Interface
- `STEPS`, 16: pattern depth, power of two; `AW = log2(STEPS)`.
- `GATE_SHIFT`, 8: gate length unit; gate cycles = `gate << GATE_SHIFT`.

- `wb_clk_i` in 1: single clock, all logic on rising edge.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `step_we` in 1: write strobe for pattern memory.
- `step_addr` in AW: step index written.
- `step_divisor` in 32: pitch divisor for the step.
- `step_gate` in 8: gate length in units of 2^GATE_SHIFT clocks; 0 = rest.
- `run` in 1: level; high = sequencer active.
- `oneshot` in 1: 1 = stop after `last_step`; 0 = loop.
- `step_period` in 27: clocks per step; values below 2 treated as 2.
- `last_step` in AW: final step index before wrap or stop.
- `divisor` out 32: pitch divisor to voice.
- `trigger` out 1: envelope gate to voice.
- `step_idx` out AW: index of the step currently playing.
- `busy` out 1: high while sequencing.
- `step_pulse` out 1: one-cycle pulse on the first cycle of every step.
- `done` out 1: one-cycle pulse when a oneshot pass completes.

## Operation
- Pattern memory is STEPS × 40 bits (`{gate, divisor}`), written when `step_we` is high. It is not reset.
- FSM has three states:
  - IDLE: waits for a rising edge of `run` (previous-cycle `run` low, current high), then goes to PLAY.
  - PLAY: plays steps, counting cycles within each step.
  - STOP: one cycle; pulses `done`, then returns to IDLE.
- Step start (cycle counter c = 0):
  - Load `divisor` and gate G = `gate << GATE_SHIFT` from memory at `step_idx`.
  - Assert `step_pulse`.
- Effective period P = max(`step_period`, 2). `step_period` and `last_step` are sampled at each step start.
- Trigger rule: `trigger` is high during cycle c iff G != 0 and c < min(G, P-1).
  - The last cycle of every step is therefore always trigger-low, so consecutive notes retrigger the envelope.
- At c = P-1:
  - If `step_idx` != `last_step`: `step_idx`+1.
  - Else, if `oneshot`=0: wrap to 0.
  - Else, if `oneshot`=1: go to STOP.
- `last_step` is compared with equality only.
  - If software lowers `last_step` below the current index, playback continues to STEPS-1 and wraps through 0.
- A memory write to the step being loaded in the same cycle is not seen. The old contents are used (read-before-write). The new value plays on that step's next visit.
- `run` falling while in PLAY:
  - Next cycle: go to IDLE, `trigger`=0, `busy`=0, `step_idx`=0.
  - `divisor` holds its last value.
  - No `done` pulse.
- `run` held high after a oneshot pass: no restart until `run` falls and rises again.
- `busy` = state is PLAY.

## Timing
- Reset values: `divisor`=0, `trigger`=0, `step_idx`=0, `busy`=0, `step_pulse`=0, `done`=0, state IDLE. The `run` edge detector is cleared.
- Reset has priority over every other input, including mid-step. All outputs take reset values on the next edge.
- `run` rises at edge N:
  - At N+1, state is PLAY, `step_idx`=0, `step_pulse`=1, `divisor`=mem[0].
  - `trigger` = (G0 != 0) at N+1.
- All outputs are registered. A step occupies exactly P cycles, so step k starts P·k cycles after step 0.
- `done` is high one cycle after the final cycle of step `last_step`. `busy` is low in that same cycle.

## Test plan
- Basic loop, GATE_SHIFT=0, P=10, `last_step`=2:
  - Steps: mem0={3,1000}, mem1={0,2000}, mem2={255,3000}.
  - `trigger` high for cycles 0-2 of step 0, low for all of step 1, high for cycles 0-8 of step 2.
  - `divisor` shows 1000/2000/3000.
  - `step_idx` wraps to 0 exactly 30 cycles after start; `step_pulse` every 10 cycles.
- Oneshot, same pattern:
  - `done` pulses once, 30 cycles after the first `step_pulse`; `busy` falls in the same cycle.
  - No restart while `run` stays high.
  - `run` toggled low then high restarts at step 0.
- Minimum period, `step_period`=0 then 1, gate=1:
  - Steps last 2 cycles.
  - `trigger` pattern is 1,0 repeated.
- Abort mid-step: `run` drops at cycle 4 of step 1 while `trigger`=1.
  - Next cycle: `trigger`=0, `busy`=0, `step_idx`=0, `divisor` unchanged, no `done`.
- Write collision: write mem1 divisor=5555 in the exact cycle step 1 loads.
  - That step plays the old 2000.
  - The next loop plays 5555.
- Reset mid-step: assert `wb_rst_i` during step 2 with `trigger` high.
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent `run` edge restarts at step 0.
